// File: rtl/cpu_decode_pkg.sv
// cpu_decode_pkg: shared types and constants for the LEGv8 decode stage.
//   - datapath width BITS, register constants (REG_ZERO, REG_LINK)
//   - opcode / condition-code constants for the decoded subset
//   - alu_op_e enum and the ctrl_t control bundle carried into ID/EX
//   - sext9 helper for the D-format address offset
package cpu_decode_pkg;

  localparam int BITS = 64;

  localparam logic [4:0] REG_ZERO = 5'd31;
  localparam logic [4:0] REG_LINK = 5'd30;

  // 11-bit R/D-format opcodes, instruction[31:21]
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // I-format, instruction[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  // CB-format, instruction[31:24]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  // B-format, instruction[31:26]
  localparam logic [5:0]  OP_B  = 6'b000101;
  localparam logic [5:0]  OP_BL = 6'b100101;

  localparam logic [3:0]  COND_LT = 4'b1011;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_EOR,
    ALU_LSL,
    ALU_LSR,
    ALU_PASSB
  } alu_op_e;

  // alu_src=1 selects ex_imm as the ALU B operand instead of ex_b.
  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    set_flags;
  } ctrl_t;

  function automatic logic [BITS-1:0] sext9(input logic [8:0] v);
    return {{(BITS-9){v[8]}}, v};
  endfunction

endpackage

// File: rtl/cpu_decode_stage_if.sv
// cpu_decode_stage_if: bundles every non-clock/reset signal of the decode stage.
//   master : the decode stage itself (consumes IF/ID + regfile data, drives
//            read addresses, branch redirect, stall and the ID/EX register)
//   slave  : the surrounding pipeline (fetch, register file, execute)
interface cpu_decode_stage_if;
  import cpu_decode_pkg::*;

  logic [31:0]     instruction;
  logic [BITS-1:0] pc_id;
  logic            flag_n;
  logic            flag_v;
  logic [BITS-1:0] ra_data;
  logic [BITS-1:0] rb_data;

  logic [4:0]      rn;
  logic [4:0]      rb;
  logic            UncondBr;
  logic            BrTaken;
  logic [18:0]     CondAddr19;
  logic [25:0]     BRAddr26;
  logic            stall_if;

  logic            ex_valid;
  ctrl_t           ex_ctrl;
  logic [4:0]      ex_rd;
  logic [BITS-1:0] ex_a;
  logic [BITS-1:0] ex_b;
  logic [BITS-1:0] ex_imm;
  logic            illegal;

  modport master (
    input  instruction, pc_id, flag_n, flag_v, ra_data, rb_data,
    output rn, rb, UncondBr, BrTaken, CondAddr19, BRAddr26, stall_if,
    output ex_valid, ex_ctrl, ex_rd, ex_a, ex_b, ex_imm, illegal
  );

  modport slave (
    output instruction, pc_id, flag_n, flag_v, ra_data, rb_data,
    input  rn, rb, UncondBr, BrTaken, CondAddr19, BRAddr26, stall_if,
    input  ex_valid, ex_ctrl, ex_rd, ex_a, ex_b, ex_imm, illegal
  );
endinterface

// File: rtl/cpu_decode_stage_hazard.sv
// decode_hazard: combinational stall / squash gating for the decode stage.
//   in : squash flop, decoded read-use bits (use_rn/use_rb), branch kind
//        (is_cbz/is_blt), raw branch decisions, read addresses, ID/EX fields
//   out: stall (hold IF/ID), gated br_taken/uncond_br, bubble into ID/EX
module decode_hazard import cpu_decode_pkg::*; (
  input  logic       squash,
  input  logic       use_rn,
  input  logic       use_rb,
  input  logic       is_cbz,
  input  logic       is_blt,
  input  logic       br_raw,
  input  logic       uncond_raw,
  input  logic [4:0] rn,
  input  logic [4:0] rb,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic       ex_set_flags,
  input  logic [4:0] ex_rd,
  output logic       stall,
  output logic       br_taken,
  output logic       uncond_br,
  output logic       bubble
);
  logic ex_rd_real;
  logic load_use;
  logic cbz_dep;
  logic flag_dep;

  always_comb begin
    // X31 is hardwired zero, so a pending write to it never feeds a reader.
    ex_rd_real = ex_valid && (ex_rd != REG_ZERO);
    load_use   = ex_rd_real && ex_mem_read &&
                 ((use_rn && (ex_rd == rn)) || (use_rb && (ex_rd == rb)));
    cbz_dep    = ex_rd_real && is_cbz && ex_reg_write && (ex_rd == rb);
    flag_dep   = ex_valid && is_blt && ex_set_flags;
    // A squashed slot is a NOP: it can neither stall nor redirect fetch.
    stall      = !squash && (load_use || cbz_dep || flag_dep);
    br_taken   = !squash && !stall && br_raw;
    uncond_br  = !squash && uncond_raw;
    bubble     = squash || stall;
  end
endmodule

// File: rtl/cpu_decode_stage.sv
// cpu_decode_stage: LEGv8 instruction-decode stage with early branch
// resolution, load-use / branch-operand hazard detection and the ID/EX
// pipeline register.
//   clk, reset (async, active-low)
//   bus (cpu_decode_stage_if.master): IF/ID word, pc_id, N/V flags, regfile
//     read data in; rn/rb, UncondBr/BrTaken/CondAddr19/BRAddr26, stall_if,
//     ex_valid/ex_ctrl/ex_rd/ex_a/ex_b/ex_imm and illegal out.
// Optional feature: define CPU_DECODE_BL_EN to decode BL (link to X30).
module cpu_decode_stage import cpu_decode_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  cpu_decode_stage_if.master bus
);
  logic [31:0]     instr;
  logic            dec_known, use_rn, use_rb, reg2loc;
  logic            is_cbz, is_blt, br_raw, uncond_raw;
  ctrl_t           ctrl_dec;
  logic [4:0]      rd_dec;
  logic [BITS-1:0] imm_dec;
  logic            stall, br_taken, uncond_br, hz_bubble;

  logic            ex_valid_q, ex_valid_d;
  ctrl_t           ex_ctrl_q, ex_ctrl_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic [BITS-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d;
  logic            illegal_q, illegal_d;
  logic            squash_q, squash_d;

  assign instr = bus.instruction;

  always_comb begin
    dec_known  = 1'b0;
    use_rn     = 1'b0;
    use_rb     = 1'b0;
    reg2loc    = 1'b0;
    is_cbz     = 1'b0;
    is_blt     = 1'b0;
    br_raw     = 1'b0;
    uncond_raw = 1'b0;
    ctrl_dec   = '0;
    rd_dec     = REG_ZERO;
    imm_dec    = '0;
    if (instr[31:21] == OP_ADDS || instr[31:21] == OP_SUBS ||
        instr[31:21] == OP_AND  || instr[31:21] == OP_EOR) begin
      dec_known          = 1'b1;
      reg2loc            = 1'b1;
      use_rn             = 1'b1;
      use_rb             = 1'b1;
      ctrl_dec.reg_write = 1'b1;
      rd_dec             = instr[4:0];
      ctrl_dec.set_flags = (instr[31:21] == OP_ADDS) || (instr[31:21] == OP_SUBS);
      if (instr[31:21] == OP_SUBS)     ctrl_dec.alu_op = ALU_SUB;
      else if (instr[31:21] == OP_AND) ctrl_dec.alu_op = ALU_AND;
      else if (instr[31:21] == OP_EOR) ctrl_dec.alu_op = ALU_EOR;
      else                             ctrl_dec.alu_op = ALU_ADD;
    end else if (instr[31:21] == OP_LSL || instr[31:21] == OP_LSR) begin
      dec_known          = 1'b1;
      reg2loc            = 1'b1;
      use_rn             = 1'b1;
      ctrl_dec.reg_write = 1'b1;
      ctrl_dec.alu_src   = 1'b1;
      ctrl_dec.alu_op    = (instr[31:21] == OP_LSL) ? ALU_LSL : ALU_LSR;
      rd_dec             = instr[4:0];
      imm_dec            = {{(BITS-6){1'b0}}, instr[15:10]};
    end else if (instr[31:22] == OP_ADDI) begin
      dec_known          = 1'b1;
      use_rn             = 1'b1;
      ctrl_dec.reg_write = 1'b1;
      ctrl_dec.alu_src   = 1'b1;
      rd_dec             = instr[4:0];
      imm_dec            = {{(BITS-12){1'b0}}, instr[21:10]};
    end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      dec_known        = 1'b1;
      use_rn           = 1'b1;
      ctrl_dec.alu_src = 1'b1;
      imm_dec          = sext9(instr[20:12]);
      if (instr[31:21] == OP_LDUR) begin
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        rd_dec              = instr[4:0];
      end else begin
        // STUR reads its store data through the rb port (Rt in [4:0]).
        use_rb             = 1'b1;
        ctrl_dec.mem_write = 1'b1;
      end
    end else if (instr[31:24] == OP_CBZ) begin
      dec_known = 1'b1;
      use_rb    = 1'b1;
      is_cbz    = 1'b1;
      br_raw    = (bus.rb_data == '0);
    end else if (instr[31:24] == OP_BCOND && instr[3:0] == COND_LT) begin
      dec_known = 1'b1;
      is_blt    = 1'b1;
      br_raw    = (bus.flag_n != bus.flag_v);
    end else if (instr[31:26] == OP_B) begin
      dec_known  = 1'b1;
      uncond_raw = 1'b1;
      br_raw     = 1'b1;
`ifdef CPU_DECODE_BL_EN
    end else if (instr[31:26] == OP_BL) begin
      dec_known          = 1'b1;
      uncond_raw         = 1'b1;
      br_raw             = 1'b1;
      ctrl_dec.reg_write = 1'b1;
      ctrl_dec.alu_src   = 1'b1;
      ctrl_dec.alu_op    = ALU_PASSB;
      rd_dec             = REG_LINK;
      imm_dec            = bus.pc_id + BITS'(4);
`endif
    end
  end

`ifndef CPU_DECODE_BL_EN
  // pc_id only feeds the BL link value.
  logic pc_id_unused;
  assign pc_id_unused = ^bus.pc_id;
`endif

  assign bus.rn         = instr[9:5];
  assign bus.rb         = reg2loc ? instr[20:16] : instr[4:0];
  assign bus.CondAddr19 = instr[23:5];
  assign bus.BRAddr26   = instr[25:0];

  decode_hazard u_hazard (
    .squash       (squash_q),
    .use_rn       (use_rn),
    .use_rb       (use_rb),
    .is_cbz       (is_cbz),
    .is_blt       (is_blt),
    .br_raw       (br_raw),
    .uncond_raw   (uncond_raw),
    .rn           (bus.rn),
    .rb           (bus.rb),
    .ex_valid     (ex_valid_q),
    .ex_mem_read  (ex_ctrl_q.mem_read),
    .ex_reg_write (ex_ctrl_q.reg_write),
    .ex_set_flags (ex_ctrl_q.set_flags),
    .ex_rd        (ex_rd_q),
    .stall        (stall),
    .br_taken     (br_taken),
    .uncond_br    (uncond_br),
    .bubble       (hz_bubble)
  );

  assign bus.stall_if = stall;
  assign bus.BrTaken  = br_taken;
  assign bus.UncondBr = uncond_br;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = '0;
    ex_rd_d    = REG_ZERO;
    ex_a_d     = '0;
    ex_b_d     = '0;
    ex_imm_d   = '0;
    if (!hz_bubble && dec_known) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = ctrl_dec;
      ex_rd_d    = rd_dec;
      ex_a_d     = bus.ra_data;
      ex_b_d     = bus.rb_data;
      ex_imm_d   = imm_dec;
    end
    illegal_d = !squash_q && !dec_known;
    // br_taken is already zero while stalled, so squash is held at 0 then.
    squash_d  = br_taken;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_rd_q    <= REG_ZERO;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      illegal_q  <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      illegal_q  <= illegal_d;
      squash_q   <= squash_d;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_ctrl  = ex_ctrl_q;
  assign bus.ex_rd    = ex_rd_q;
  assign bus.ex_a     = ex_a_q;
  assign bus.ex_b     = ex_b_q;
  assign bus.ex_imm   = ex_imm_q;
  assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_cpu_decode_stage.sv
// tb_cpu_decode_stage: directed-vector bench for cpu_decode_stage.
// Honours CPU_DECODE_BL_EN to select the expected BL response.
module tb_cpu_decode_stage;
  import cpu_decode_pkg::*;

  // Independent opcode encodings for building stimulus.
  localparam logic [10:0] E_ADDS = 11'b10101011000;
  localparam logic [10:0] E_SUBS = 11'b11101011000;
  localparam logic [10:0] E_LDUR = 11'b11111000010;
  localparam logic [7:0]  E_CBZ  = 8'b10110100;
  localparam logic [7:0]  E_BC   = 8'b01010100;
  localparam logic [5:0]  E_B    = 6'b000101;
  localparam logic [5:0]  E_BL   = 6'b100101;

  localparam logic [63:0] RA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RB = 64'hAAAA_BBBB_CCCC_DDDD;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  cpu_decode_stage_if bus ();

  cpu_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] off,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, off, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] off,
                                         input logic [4:0] rt);
    return {op, off, rt};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input string what);
    bus.instruction = ins;
    #1;
    $display("txn t=%0t %s instr=%h stall=%0b br=%0b ub=%0b", $time, what, ins,
             bus.stall_if, bus.BrTaken, bus.UncondBr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b0;
    bus.instruction = 32'hFFFF_FFFF;
    bus.pc_id       = 64'h1000;
    bus.flag_n      = 1'b0;
    bus.flag_v      = 1'b0;
    bus.ra_data     = RA;
    bus.rb_data     = RB;
    step();
    step();
    check_eq("rst_valid", bus.ex_valid, 0);
    check_eq("rst_ctrl", 64'(bus.ex_ctrl), 0);
    check_eq("rst_rd", bus.ex_rd, 31);
    check_eq("rst_imm", bus.ex_imm, 0);
    check_eq("rst_illegal", bus.illegal, 0);
    reset = 1'b1;

    // ADDS X1,X2,X3
    issue(enc_r(E_ADDS, 5'd3, 5'd2, 5'd1), "ADDS X1,X2,X3");
    check_eq("adds_rn", bus.rn, 2);
    check_eq("adds_rb", bus.rb, 3);
    check_eq("adds_stall", bus.stall_if, 0);
    step();
    check_eq("adds_valid", bus.ex_valid, 1);
    check_eq("adds_aluop", 64'(bus.ex_ctrl.alu_op), 64'(ALU_ADD));
    check_eq("adds_flags", bus.ex_ctrl.set_flags, 1);
    check_eq("adds_rd", bus.ex_rd, 1);
    check_eq("adds_a", bus.ex_a, RA);
    check_eq("adds_b", bus.ex_b, RB);

    // LDUR X5,[X6,#-8] then ADDS X7,X5,X8 -> one load-use stall
    issue(enc_d(E_LDUR, 9'h1F8, 5'd6, 5'd5), "LDUR X5,[X6,#-8]");
    check_eq("ldur_rb", bus.rb, 5);
    check_eq("ldur_stall", bus.stall_if, 0);
    step();
    check_eq("ldur_memrd", bus.ex_ctrl.mem_read, 1);
    check_eq("ldur_rd", bus.ex_rd, 5);
    check_eq("ldur_imm", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    issue(enc_r(E_ADDS, 5'd8, 5'd5, 5'd7), "ADDS X7,X5,X8");
    check_eq("lu_stall", bus.stall_if, 1);
    step();
    check_eq("lu_bubble", bus.ex_valid, 0);
    check_eq("lu_bubble_ctrl", 64'(bus.ex_ctrl), 0);
    check_eq("lu_stall_end", bus.stall_if, 0);
    step();
    check_eq("lu_issue", bus.ex_valid, 1);
    check_eq("lu_issue_rd", bus.ex_rd, 7);

    // CBZ X4: not taken, then taken; following slot squashed
    bus.rb_data = 64'd5;
    issue(enc_cb(E_CBZ, 19'h2ABCD, 5'd4), "CBZ X4");
    check_eq("cbz_nt", bus.BrTaken, 0);
    bus.rb_data = 64'd0;
    #1;
    check_eq("cbz_t", bus.BrTaken, 1);
    check_eq("cbz_ub", bus.UncondBr, 0);
    check_eq("cbz_addr", bus.CondAddr19, 19'h2ABCD);
    step();
    check_eq("cbz_valid", bus.ex_valid, 1);
    check_eq("cbz_rd", bus.ex_rd, 31);
    bus.rb_data = RB;
    issue({E_B, 26'h0123456}, "B (squashed)");
    check_eq("sq_br", bus.BrTaken, 0);
    check_eq("sq_ub", bus.UncondBr, 0);
    step();
    check_eq("sq_valid", bus.ex_valid, 0);
    issue({E_B, 26'h0123456}, "B");
    check_eq("b_ub", bus.UncondBr, 1);
    check_eq("b_br", bus.BrTaken, 1);
    check_eq("b_addr", bus.BRAddr26, 26'h0123456);
    step();
    issue(32'hFFFF_FFFF, "illegal (squashed)");
    step();
    check_eq("sq_ill_pulse", bus.illegal, 0);
    check_eq("sq_ill_valid", bus.ex_valid, 0);

    // Undecodable word
    issue(32'hFFFF_FFFF, "illegal");
    step();
    check_eq("ill_pulse", bus.illegal, 1);
    check_eq("ill_valid", bus.ex_valid, 0);
    issue(enc_r(E_ADDS, 5'd3, 5'd2, 5'd1), "ADDS X1,X2,X3");
    step();
    check_eq("ill_clear", bus.illegal, 0);

    // SUBS then B.LT with N!=V -> one flag stall then taken
    issue(enc_r(E_SUBS, 5'd2, 5'd1, 5'd9), "SUBS X9,X1,X2");
    step();
    bus.flag_n = 1'b1;
    bus.flag_v = 1'b0;
    issue(enc_cb(E_BC, 19'h00042, 5'b01011), "B.LT");
    check_eq("blt_stall", bus.stall_if, 1);
    check_eq("blt_br_held", bus.BrTaken, 0);
    step();
    check_eq("blt_bubble", bus.ex_valid, 0);
    check_eq("blt_stall_end", bus.stall_if, 0);
    check_eq("blt_br", bus.BrTaken, 1);
    check_eq("blt_ub", bus.UncondBr, 0);
    step();
    issue(32'hFFFF_FFFF, "filler (squashed)");
    step();

    // X31 is never a load-use source
    issue(enc_d(E_LDUR, 9'h008, 5'd6, 5'd31), "LDUR X31,[X6,#8]");
    step();
    issue(enc_r(E_ADDS, 5'd31, 5'd31, 5'd1), "ADDS X1,X31,X31");
    check_eq("x31_stall", bus.stall_if, 0);
    step();

    // BL
    issue({E_BL, 26'h0000100}, "BL");
`ifdef CPU_DECODE_BL_EN
    check_eq("bl_ub", bus.UncondBr, 1);
    check_eq("bl_br", bus.BrTaken, 1);
    step();
    check_eq("bl_valid", bus.ex_valid, 1);
    check_eq("bl_rd", bus.ex_rd, 30);
    check_eq("bl_imm", bus.ex_imm, 64'h1004);
    check_eq("bl_wr", bus.ex_ctrl.reg_write, 1);
    check_eq("bl_aluop", 64'(bus.ex_ctrl.alu_op), 64'(ALU_PASSB));
`else
    check_eq("bl_ub", bus.UncondBr, 0);
    check_eq("bl_br", bus.BrTaken, 0);
    step();
    check_eq("bl_valid", bus.ex_valid, 0);
    check_eq("bl_illegal", bus.illegal, 1);
`endif
    issue(enc_r(E_ADDS, 5'd3, 5'd2, 5'd1), "ADDS X1,X2,X3");
    step();

    // Reset asserted mid-stall
    issue(enc_d(E_LDUR, 9'h1F8, 5'd6, 5'd5), "LDUR X5,[X6,#-8]");
    step();
    issue(enc_r(E_ADDS, 5'd8, 5'd5, 5'd7), "ADDS X7,X5,X8");
    check_eq("rs_stall", bus.stall_if, 1);
    reset = 1'b0;
    #1;
    check_eq("rs_valid", bus.ex_valid, 0);
    check_eq("rs_ctrl", 64'(bus.ex_ctrl), 0);
    check_eq("rs_rd", bus.ex_rd, 31);
    check_eq("rs_a", bus.ex_a, 0);
    check_eq("rs_imm", bus.ex_imm, 0);
    check_eq("rs_stall_clr", bus.stall_if, 0);
    step();
    reset = 1'b1;
    step();

    // Reset asserted mid-squash
    issue({E_B, 26'h0000010}, "B");
    step();
    check_eq("rq_squashed", bus.BrTaken, 0);
    reset = 1'b0;
    #1;
    check_eq("rq_squash_clr", bus.BrTaken, 1);
    check_eq("rq_valid", bus.ex_valid, 0);
    issue(enc_r(E_ADDS, 5'd3, 5'd2, 5'd1), "ADDS X1,X2,X3");
    reset = 1'b1;
    step();
    check_eq("post_rst_valid", bus.ex_valid, 1);
    check_eq("post_rst_rd", bus.ex_rd, 1);
    check_eq("post_rst_a", bus.ex_a, RA);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
